// File: rtl/mmio_timer.sv
// Memory-mapped prescaled 32-bit timer with compare match, auto-reload and level interrupt.
// Sits on the core's data bus next to data_memory; ReadData is zero when not selected so the two paths OR together.
module mmio_timer #(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
    parameter int          PRESCALE_W = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] ReadData,
    output logic        Hit,
    output logic        Irq
);

    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_PRESCALE = 3'd1;
    localparam logic [2:0] OFF_COUNT    = 3'd2;
    localparam logic [2:0] OFF_COMPARE  = 3'd3;
    localparam logic [2:0] OFF_STATUS   = 3'd4;

    localparam logic [PRESCALE_W-1:0] PCNT_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    // ctrl bits: [0] EN, [1] AR (auto-reload), [2] IE
    logic [2:0]            ctrl_q, ctrl_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
    logic [31:0]           count_q, count_d;
    logic [31:0]           compare_q, compare_d;
    logic                  match_q, match_d;
    logic                  wrap_q, wrap_d;

    logic [2:0]  offset;
    logic        wr_en;
    logic        wr_ctrl, wr_prescale, wr_count, wr_compare, wr_status;
    logic        tick;
    logic        cmp_eq;
    logic [32:0] count_inc;
    logic        match_set, wrap_set;
    logic        unused_bits;

    assign Hit         = (Address[31:5] == BASE_ADDR[31:5]);
    assign offset      = Address[4:2];
    assign wr_en       = MemWrite & Hit;
    assign unused_bits = ^Address[1:0];

    // Bus access: no handshake. A read is combinational in the cycle MemRead&Hit is high and always
    // reflects the pre-edge register values; a write commits on the rising Clk edge of a MemWrite&Hit cycle.
    always_comb begin
        wr_ctrl     = 1'b0;
        wr_prescale = 1'b0;
        wr_count    = 1'b0;
        wr_compare  = 1'b0;
        wr_status   = 1'b0;
        if (wr_en) begin
            case (offset)
                OFF_CTRL:     wr_ctrl     = 1'b1;
                OFF_PRESCALE: wr_prescale = 1'b1;
                OFF_COUNT:    wr_count    = 1'b1;
                OFF_COMPARE:  wr_compare  = 1'b1;
                OFF_STATUS:   wr_status   = 1'b1;
                default:      ;
            endcase
        end
    end

    always_comb begin
        ReadData = '0;
        if (Hit && MemRead) begin
            case (offset)
                OFF_CTRL:     ReadData = {29'd0, ctrl_q};
                OFF_PRESCALE: ReadData = 32'(prescale_q);
                OFF_COUNT:    ReadData = count_q;
                OFF_COMPARE:  ReadData = compare_q;
                OFF_STATUS:   ReadData = {30'd0, wrap_q, match_q};
                default:      ReadData = '0;
            endcase
        end
    end

    assign tick      = ctrl_q[0] && (pcnt_q == prescale_q);
    assign cmp_eq    = (count_q == compare_q);
    assign count_inc = {1'b0, count_q} + 33'd1;

    // Counter path: a CPU write to COUNT overrides the tick and suppresses match/wrap for that cycle.
    always_comb begin
        pcnt_d    = pcnt_q;
        count_d   = count_q;
        match_set = 1'b0;
        wrap_set  = 1'b0;
        if (tick) begin
            pcnt_d = '0;
            if (cmp_eq) begin
                match_set = 1'b1;
                count_d   = ctrl_q[1] ? 32'd0 : count_inc[31:0];
                wrap_set  = !ctrl_q[1] && count_inc[32];
            end else begin
                count_d  = count_inc[31:0];
                wrap_set = count_inc[32];
            end
        end else if (ctrl_q[0]) begin
            pcnt_d = pcnt_q + PCNT_ONE;
        end
        if (wr_prescale) begin
            pcnt_d = '0;
        end
        if (wr_count) begin
            count_d   = WriteData;
            match_set = 1'b0;
            wrap_set  = 1'b0;
        end
    end

    // Status bits are W1C, but a set event in the same cycle wins over the clear.
    always_comb begin
        ctrl_d     = wr_ctrl ? WriteData[2:0] : ctrl_q;
        prescale_d = wr_prescale ? WriteData[PRESCALE_W-1:0] : prescale_q;
        compare_d  = wr_compare ? WriteData : compare_q;
        match_d    = match_set | (match_q & ~(wr_status & WriteData[0]));
        wrap_d     = wrap_set | (wrap_q & ~(wr_status & WriteData[1]));
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ctrl_q     <= '0;
            prescale_q <= '0;
            pcnt_q     <= '0;
            count_q    <= '0;
            compare_q  <= 32'hFFFF_FFFF;
            match_q    <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            match_q    <= match_d;
            wrap_q     <= wrap_d;
        end
    end

    assign Irq = match_q & ctrl_q[2];

endmodule

// File: tb/tb_mmio_timer.sv
// Bench for mmio_timer: directed scenarios with fixed expectations plus a randomized run checked
// against a cycle-level behavioural model of the register map.
module tb_mmio_timer;

    localparam logic [31:0] BASE = 32'hFFFF_0000;
    localparam int          PW   = 16;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;
    logic        Hit;
    logic        Irq;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // behavioural model state
    logic [2:0]    m_ctrl;
    logic [PW-1:0] m_prescale;
    int unsigned   m_pcnt;
    logic [31:0]   m_count;
    logic [31:0]   m_compare;
    logic          m_match;
    logic          m_wrap;

    // last bus cycle: observed and model-expected values
    logic [31:0] obs_rd, exp_rd;
    logic        obs_irq, exp_irq, obs_hit, exp_hit;

    mmio_timer #(
        .BASE_ADDR  (BASE),
        .PRESCALE_W (PW)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Address   (Address),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .ReadData  (ReadData),
        .Hit       (Hit),
        .Irq       (Irq)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic void model_reset();
        m_ctrl     = '0;
        m_prescale = '0;
        m_pcnt     = 0;
        m_count    = '0;
        m_compare  = 32'hFFFF_FFFF;
        m_match    = 1'b0;
        m_wrap     = 1'b0;
    endfunction

    function automatic logic model_hit(input logic [31:0] addr);
        return (addr & 32'hFFFF_FFE0) == BASE;
    endfunction

    function automatic logic [31:0] model_read(input logic re, input logic [31:0] addr);
        if (!re || !model_hit(addr)) return 32'd0;
        case ((addr >> 2) & 32'd7)
            0: return {29'd0, m_ctrl};
            1: return 32'(m_prescale);
            2: return m_count;
            3: return m_compare;
            4: return {30'd0, m_wrap, m_match};
            default: return 32'd0;
        endcase
    endfunction

    function automatic void model_step(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        bit               tick  = 0;
        bit               set_m = 0;
        bit               set_w = 0;
        longint unsigned  nxt   = 64'(m_count);
        int unsigned      npcnt = m_pcnt;
        int unsigned      off   = (addr >> 2) & 32'd7;
        if (m_ctrl[0]) begin
            if (m_pcnt == int'(m_prescale)) begin
                tick  = 1;
                npcnt = 0;
            end else begin
                npcnt = m_pcnt + 1;
            end
        end
        if (tick) begin
            if (m_count == m_compare) begin
                set_m = 1;
                nxt   = m_ctrl[1] ? 64'd0 : 64'(m_count) + 64'd1;
            end else begin
                nxt = 64'(m_count) + 64'd1;
            end
            if (nxt == 64'h1_0000_0000) begin
                nxt   = 0;
                set_w = 1;
            end
        end
        if (we && model_hit(addr)) begin
            case (off)
                0: m_ctrl = wdata[2:0];
                1: begin m_prescale = wdata[PW-1:0]; npcnt = 0; end
                2: begin nxt = 64'(wdata); set_m = 0; set_w = 0; end
                3: m_compare = wdata;
                4: begin
                    if (wdata[0]) m_match = 1'b0;
                    if (wdata[1]) m_wrap = 1'b0;
                end
                default: ;
            endcase
        end
        m_count = nxt[31:0];
        m_pcnt  = npcnt;
        if (set_m) m_match = 1'b1;
        if (set_w) m_wrap = 1'b1;
    endfunction

    // ---------------- driver tasks ----------------
    // Called at posedge+1; samples outputs at the negedge, advances the model, returns at next posedge+1.
    task automatic bus_cycle(input logic we, input logic re, input logic [31:0] addr, input logic [31:0] wdata);
        MemWrite  = we;
        MemRead   = re;
        Address   = addr;
        WriteData = wdata;
        exp_rd    = model_read(re, addr);
        exp_irq   = m_match & m_ctrl[2];
        exp_hit   = model_hit(addr);
        @(negedge Clk);
        obs_rd  = ReadData;
        obs_irq = Irq;
        obs_hit = Hit;
        model_step(we, addr, wdata);
        @(posedge Clk);
        #1;
        MemWrite = 1'b0;
        MemRead  = 1'b0;
    endtask

    task automatic wr(input int off, input logic [31:0] data);
        bus_cycle(1'b1, 1'b0, BASE + 32'(off * 4), data);
    endtask

    task automatic rd(input int off);
        bus_cycle(1'b0, 1'b1, BASE + 32'(off * 4), 32'd0);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        model_reset();
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] exp;
        wr(2, 32'd5);
        wr(0, 32'd1);
        rd(2);
        total_cnt++;
        if (obs_rd !== 32'd5) $display("FAIL pre_reset_count got %0h want %0h", obs_rd, 32'd5);
        else pass_cnt++;
        rd(2);
        total_cnt++;
        if (obs_rd !== 32'd6) $display("FAIL pre_reset_count2 got %0h want %0h", obs_rd, 32'd6);
        else pass_cnt++;
        #3;
        Reset = 1'b1;
        model_reset();
        MemRead = 1'b1;
        Address = BASE + 32'h8;
        #1;
        total_cnt++;
        if (ReadData !== 32'd0) $display("FAIL async_reset_count got %0h want 0", ReadData);
        else pass_cnt++;
        total_cnt++;
        if (Irq !== 1'b0) $display("FAIL async_reset_irq got %0b want 0", Irq);
        else pass_cnt++;
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Reset   = 1'b0;
        MemRead = 1'b0;
        for (int off = 0; off < 8; off++) begin
            rd(off);
            exp = (off == 3) ? 32'hFFFF_FFFF : 32'd0;
            total_cnt++;
            if (obs_rd !== exp) $display("FAIL reset_read off=%0d got %0h want %0h", off, obs_rd, exp);
            else pass_cnt++;
            total_cnt++;
            if (obs_irq !== 1'b0) $display("FAIL reset_irq off=%0d got %0b want 0", off, obs_irq);
            else pass_cnt++;
        end
        bus_cycle(1'b0, 1'b1, 32'h0000_0008, 32'd0);
        total_cnt++;
        if (obs_rd !== 32'd0 || obs_hit !== 1'b0)
            $display("FAIL reset_nonhit_read got rd=%0h hit=%0b want rd=0 hit=0", obs_rd, obs_hit);
        else pass_cnt++;
    endtask

    task automatic test_prescale();
        wr(0, 32'd0);
        wr(1, 32'd3);
        wr(2, 32'd0);
        wr(0, 32'd1);
        for (int i = 0; i <= 40; i++) begin
            rd(2);
            total_cnt++;
            if (obs_rd !== 32'(i / 4)) $display("FAIL prescale_count cyc=%0d got %0d want %0d", i, obs_rd, i / 4);
            else pass_cnt++;
        end
        wr(0, 32'd0);
    endtask

    task automatic test_autoreload();
        wr(0, 32'd0);
        wr(4, 32'd3);
        wr(1, 32'd0);
        wr(3, 32'd7);
        wr(2, 32'd0);
        wr(0, 32'd7);
        for (int i = 0; i < 16; i++) begin
            rd(2);
            total_cnt++;
            if (obs_rd !== 32'(i % 8)) $display("FAIL autoreload_count cyc=%0d got %0d want %0d", i, obs_rd, i % 8);
            else pass_cnt++;
            total_cnt++;
            if (obs_irq !== (i >= 8)) $display("FAIL autoreload_irq cyc=%0d got %0b want %0b", i, obs_irq, i >= 8);
            else pass_cnt++;
        end
        wr(4, 32'd1);
        rd(4);
        total_cnt++;
        if (obs_rd !== 32'd0) $display("FAIL w1c_match_clear got %0h want 0", obs_rd);
        else pass_cnt++;
        total_cnt++;
        if (obs_irq !== 1'b0) $display("FAIL w1c_irq_drop got %0b want 0", obs_irq);
        else pass_cnt++;
        wr(0, 32'd0);
        wr(4, 32'd3);
    endtask

    task automatic test_wrap();
        logic [31:0] seq [3];
        seq[0] = 32'hFFFF_FFFE;
        seq[1] = 32'hFFFF_FFFF;
        seq[2] = 32'd0;
        do_reset();
        wr(1, 32'd0);
        wr(2, 32'hFFFF_FFFE);
        wr(0, 32'd1);
        for (int i = 0; i < 3; i++) begin
            rd(2);
            total_cnt++;
            if (obs_rd !== seq[i]) $display("FAIL wrap_count cyc=%0d got %0h want %0h", i, obs_rd, seq[i]);
            else pass_cnt++;
        end
        rd(4);
        total_cnt++;
        if (obs_rd !== 32'd3) $display("FAIL wrap_status got %0h want 3", obs_rd);
        else pass_cnt++;
        total_cnt++;
        if (obs_irq !== 1'b0) $display("FAIL wrap_irq_ie0 got %0b want 0", obs_irq);
        else pass_cnt++;
        wr(0, 32'd0);
        wr(4, 32'd3);
    endtask

    task automatic test_collision();
        wr(0, 32'd0);
        wr(4, 32'd3);
        wr(1, 32'd0);
        wr(3, 32'd7);
        wr(2, 32'd0);
        wr(0, 32'd3);
        wr(2, 32'd100);
        rd(2);
        total_cnt++;
        if (obs_rd !== 32'd100) $display("FAIL count_write_beats_tick got %0d want 100", obs_rd);
        else pass_cnt++;
        wr(2, 32'd5);
        rd(2);
        total_cnt++;
        if (obs_rd !== 32'd5) $display("FAIL collision_count5 got %0d want 5", obs_rd);
        else pass_cnt++;
        rd(2);
        total_cnt++;
        if (obs_rd !== 32'd6) $display("FAIL collision_count6 got %0d want 6", obs_rd);
        else pass_cnt++;
        wr(4, 32'd1);
        rd(4);
        total_cnt++;
        if (obs_rd !== 32'd1) $display("FAIL match_set_beats_w1c got %0h want 1", obs_rd);
        else pass_cnt++;
        wr(0, 32'd0);
        wr(4, 32'd3);
    endtask

    task automatic test_decode();
        logic [31:0] exp [5];
        exp[0] = 32'd0;
        exp[1] = 32'd2;
        exp[2] = 32'h1234;
        exp[3] = 32'h99;
        exp[4] = 32'd0;
        wr(0, 32'd0);
        wr(1, 32'd2);
        wr(2, 32'h1234);
        wr(3, 32'h99);
        wr(4, 32'd3);
        bus_cycle(1'b1, 1'b0, BASE + 32'h20, 32'h55);
        total_cnt++;
        if (obs_hit !== 1'b0) $display("FAIL decode_hit_0x20 got %0b want 0", obs_hit);
        else pass_cnt++;
        bus_cycle(1'b1, 1'b0, BASE + 32'h18, 32'h55);
        total_cnt++;
        if (obs_hit !== 1'b1) $display("FAIL decode_hit_0x18 got %0b want 1", obs_hit);
        else pass_cnt++;
        for (int off = 0; off < 5; off++) begin
            rd(off);
            total_cnt++;
            if (obs_rd !== exp[off]) $display("FAIL decode_unchanged off=%0d got %0h want %0h", off, obs_rd, exp[off]);
            else pass_cnt++;
        end
        rd(6);
        total_cnt++;
        if (obs_rd !== 32'd0) $display("FAIL reserved_read got %0h want 0", obs_rd);
        else pass_cnt++;
        bus_cycle(1'b0, 1'b1, BASE + 32'h20, 32'd0);
        total_cnt++;
        if (obs_rd !== 32'd0) $display("FAIL nonhit_read got %0h want 0", obs_rd);
        else pass_cnt++;
        bus_cycle(1'b0, 1'b0, BASE + 32'h8, 32'd0);
        total_cnt++;
        if (obs_rd !== 32'd0) $display("FAIL no_memread_read got %0h want 0", obs_rd);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        wr(3, 32'h1111);
        bus_cycle(1'b1, 1'b1, BASE + 32'hC, 32'h2222);
        total_cnt++;
        if (obs_rd !== 32'h1111) $display("FAIL rw_same_cycle_old got %0h want 1111", obs_rd);
        else pass_cnt++;
        wr(3, 32'h3333);
        rd(3);
        total_cnt++;
        if (obs_rd !== 32'h3333) $display("FAIL back_to_back_write got %0h want 3333", obs_rd);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic        we, re;
        logic [31:0] addr, data;
        int unsigned off;
        for (int n = 0; n < 500; n++) begin
            we  = ($urandom_range(0, 3) == 0);
            re  = $urandom_range(0, 1) == 1;
            off = $urandom_range(0, 7);
            if ($urandom_range(0, 7) == 0) addr = $urandom();
            else addr = BASE + (off << 2) + 32'($urandom_range(0, 3));
            case (off)
                0: data = ($urandom() & 32'hFFFF_FFF8) | 32'($urandom_range(0, 7));
                1: data = 32'($urandom_range(0, 3));
                2, 3: data = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                         : 32'($urandom_range(0, 20));
                4: data = 32'($urandom_range(0, 3));
                default: data = $urandom();
            endcase
            bus_cycle(we, re, addr, data);
            total_cnt++;
            if (obs_rd !== exp_rd) $display("FAIL random_read n=%0d addr=%0h got %0h want %0h", n, addr, obs_rd, exp_rd);
            else pass_cnt++;
            total_cnt++;
            if (obs_irq !== exp_irq || obs_hit !== exp_hit)
                $display("FAIL random_irq_hit n=%0d got irq=%0b hit=%0b want irq=%0b hit=%0b",
                         n, obs_irq, obs_hit, exp_irq, exp_hit);
            else pass_cnt++;
        end
    endtask

    initial begin
        Reset     = 1'b1;
        Address   = '0;
        WriteData = '0;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        model_reset();
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        test_reset();
        test_prescale();
        test_autoreload();
        test_wrap();
        test_collision();
        test_decode();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
